dmem_resp_ws: RTL

//  Data-memory responder with wait states, the slave end of the core's load/store port.

---
 rtl/dmem_resp_ws_pkg.sv | 21 ++
 rtl/dmem_resp_ws_if.sv | 38 +++
 rtl/dmem_array.sv | 50 +++++
 rtl/dmem_resp_ws.sv | 124 ++++++++++++
 4 files changed

// File: rtl/dmem_resp_ws_pkg.sv
// ---------------------------------------------------------------------------
// dmem_resp_ws_pkg
// Shared definitions for the wait-state data-memory responder: the responder
// FSM state encoding, the data word width, the number of byte lanes per word
// and the width of the wait-state counter.
// ---------------------------------------------------------------------------
package dmem_resp_ws_pkg;

    localparam int WORD_BITS  = 32;
    localparam int BYTE_LANES = 4;

    // Wide enough for any wait count from 0 to 15.
    localparam int CNT_BITS   = $clog2(16);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_resp_ws_if.sv
// ---------------------------------------------------------------------------
// dmem_resp_ws_if
// Load/store port between the core (master) and the data-memory responder
// (slave).
//   req    master->slave  request valid, held until ready is seen
//   we     master->slave  1 = store, 0 = load
//   addr   master->slave  byte address (word aligned)
//   be     master->slave  store byte enables, be[i] -> wdata[8i+7:8i]
//   wdata  master->slave  store data
//   ready  slave->master  responder idle, request may be accepted
//   rvalid slave->master  one-cycle response pulse
//   rdata  slave->master  load data while rvalid, otherwise 0
//   err    slave->master  misaligned or out-of-range request, with rvalid
// ---------------------------------------------------------------------------
interface dmem_resp_ws_if;
    import dmem_resp_ws_pkg::*;

    logic                  req;
    logic                  we;
    logic [WORD_BITS-1:0]  addr;
    logic [BYTE_LANES-1:0] be;
    logic [WORD_BITS-1:0]  wdata;
    logic                  ready;
    logic                  rvalid;
    logic [WORD_BITS-1:0]  rdata;
    logic                  err;

    modport master (
        output req, we, addr, be, wdata,
        input  ready, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output ready, rvalid, rdata, err
    );

endinterface

// File: rtl/dmem_array.sv
// ---------------------------------------------------------------------------
// dmem_array
// Single-port synchronous word RAM with byte-lane write enables. No reset:
// contents survive a responder reset. Read data is registered on the edge
// where the array is enabled for a load and holds until the next load.
//   clk      clock
//   i_en     access enable for this edge
//   i_we     1 = write the enabled byte lanes, 0 = read the word
//   i_be     byte-lane write enables
//   i_widx   word index
//   i_wdata  write data
//   o_rdata  registered read data
// ---------------------------------------------------------------------------
module dmem_array
    import dmem_resp_ws_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                  clk,
    input  logic                  i_en,
    input  logic                  i_we,
    input  logic [BYTE_LANES-1:0] i_be,
    input  logic [IDX_W-1:0]      i_widx,
    input  logic [WORD_BITS-1:0]  i_wdata,
    output logic [WORD_BITS-1:0]  o_rdata
);

    logic [WORD_BITS-1:0] r_mem [DEPTH_WORDS];
    logic [WORD_BITS-1:0] r_rdata;

    // Lanes with a clear enable keep their old byte, so a partial store is a
    // read-modify-write without any read port traffic.
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                for (int i = 0; i < BYTE_LANES; i++) begin
                    if (i_be[i]) begin
                        r_mem[i_widx][8*i +: 8] <= i_wdata[8*i +: 8];
                    end
                end
            end else begin
                r_rdata <= r_mem[i_widx];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_resp_ws.sv
// ---------------------------------------------------------------------------
// dmem_resp_ws
// Data-memory responder with wait states. Accepts one request at a time,
// holds it for WAIT_CYCLES cycles, commits the store or fetches the load word
// on the edge entering RESP, and returns a one-cycle rvalid response. Bad
// requests (misaligned or beyond the array) never touch the array but follow
// identical timing and report err with rvalid.
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    slave side of the load/store port
// ---------------------------------------------------------------------------
module dmem_resp_ws
    import dmem_resp_ws_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input logic           clk,
    input logic           rst_n,
    dmem_resp_ws_if.slave bus
);

    localparam int                  IDX_W     = $clog2(DEPTH_WORDS);
    localparam bit                  ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [CNT_BITS-1:0] WAIT_LOAD = CNT_BITS'(WAIT_CYCLES);
    localparam logic [CNT_BITS-1:0] CNT_ONE   = CNT_BITS'(1);

    state_t                r_state;
    logic [CNT_BITS-1:0]   r_cnt;
    logic                  r_we;
    logic [WORD_BITS-1:0]  r_addr;
    logic [BYTE_LANES-1:0] r_be;
    logic [WORD_BITS-1:0]  r_wdata;
    logic                  r_err;

    logic                  w_accept;
    logic                  w_commit;
    logic                  w_cWe;
    logic [WORD_BITS-1:0]  w_cAddr;
    logic [BYTE_LANES-1:0] w_cBe;
    logic [WORD_BITS-1:0]  w_cWdata;
    logic                  w_cErr;
    logic [WORD_BITS-1:0]  w_arrRdata;

    assign w_accept = (r_state == ST_IDLE) && bus.req;

    // With no wait states the commit happens on the accepting edge itself,
    // so the array must see the live request rather than the latches.
    assign w_commit = ZERO_WAIT ? w_accept
                                : ((r_state == ST_WAIT) && (r_cnt == CNT_ONE));
    assign w_cWe    = ZERO_WAIT ? bus.we    : r_we;
    assign w_cAddr  = ZERO_WAIT ? bus.addr  : r_addr;
    assign w_cBe    = ZERO_WAIT ? bus.be    : r_be;
    assign w_cWdata = ZERO_WAIT ? bus.wdata : r_wdata;

    // Compare the full word index so addresses beyond the array are rejected
    // instead of wrapping onto low words.
    assign w_cErr = (w_cAddr[1:0] != 2'b00) ||
                    ({2'b00, w_cAddr[WORD_BITS-1:2]} >= WORD_BITS'(DEPTH_WORDS));

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk     (clk),
        .i_en    (w_commit && !w_cErr),
        .i_we    (w_cWe),
        .i_be    (w_cBe),
        .i_widx  (w_cAddr[2 +: IDX_W]),
        .i_wdata (w_cWdata),
        .o_rdata (w_arrRdata)
    );

    // Responder FSM: request latches load on acceptance, the counter paces
    // WAIT, and the error flag is captured on the commit edge so it lines up
    // with the response cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_be    <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req) begin
                        r_we    <= bus.we;
                        r_addr  <= bus.addr;
                        r_be    <= bus.be;
                        r_wdata <= bus.wdata;
                        r_cnt   <= WAIT_LOAD;
                        r_state <= ZERO_WAIT ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) begin
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
            if (w_commit) begin
                r_err <= w_cErr;
            end
        end
    end

    // Response outputs decode the state register; data and error are forced
    // to zero outside the response cycle and for stores or bad requests.
    assign bus.ready  = (r_state == ST_IDLE);
    assign bus.rvalid = (r_state == ST_RESP);
    assign bus.err    = (r_state == ST_RESP) && r_err;
    assign bus.rdata  = ((r_state == ST_RESP) && !r_we && !r_err) ? w_arrRdata : '0;

endmodule
